// File: rtl/countdown_pkg.sv
// Shared state encoding, LED width and width helper for the countdown sequencer.
// Pure declarations: no logic, no latency, no flow control.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int LED_W = 15;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop sync -> stability counter -> one-cycle pulse on accepted press.
// Press-to-pulse latency 2+DB_CYCLES cycles; no backpressure, release never pulses.
module btn_debounce
    import countdown_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int             CW      = clog2(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            pulse  <= 1'b0;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync_b == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt    <= '0;
                stable <= sync_b;
                pulse  <= sync_b;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_ctrl.sv
// Run/pause/clear sequencer for the MM:SS countdown: debounce, 1 Hz strobe, reload, LED bar.
// load/cnt_en registered one cycle after their cause; no backpressure.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TICK_HZ     = 1,
    parameter int DB_CYCLES   = 1_000_000,
    parameter int BLINK_TICKS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_sp,
    input  logic             btn_clr,
    input  logic             cnt_zero,
    output logic             load,
    output logic             cnt_en,
    output logic [1:0]       state,
    output logic [LED_W-1:0] led
);

    localparam int            DIV       = CLK_HZ / TICK_HZ;
    localparam int            PW        = clog2(DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam int            BW        = clog2(BLINK_TICKS);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

    state_t        st;
    state_t        st_nxt;
    logic          sp_p;
    logic          clr_p;
    logic          tick;
    logic          load_nxt;
    logic          cnt_en_nxt;
    logic          hb;
    logic          phase;
    logic [PW-1:0] presc;
    logic [BW-1:0] bcnt;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sp (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_sp),
        .pulse (sp_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clr),
        .pulse (clr_p)
    );

    assign tick  = ((st == ST_RUN) || (st == ST_DONE)) && (presc == PRESC_MAX);
    assign state = st;

    // Prescaler holds its partial second through PAUSE so resume is seamless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else begin
            case (st)
                ST_IDLE:  presc <= '0;
                ST_PAUSE: presc <= presc;
                default:  presc <= tick ? '0 : presc + 1'b1;
            endcase
        end
    end

    always_comb begin
        st_nxt     = st;
        load_nxt   = 1'b0;
        cnt_en_nxt = 1'b0;
        case (st)
            ST_IDLE: begin
                if (clr_p) begin
                    load_nxt = 1'b1;
                end else if (sp_p && !cnt_zero) begin
                    st_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clr_p) begin
                    st_nxt   = ST_IDLE;
                    load_nxt = 1'b1;
                end else if (sp_p) begin
                    st_nxt = ST_PAUSE;
                end else if (tick) begin
                    if (cnt_zero) begin
                        st_nxt = ST_DONE;
                    end else begin
                        cnt_en_nxt = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (clr_p) begin
                    st_nxt   = ST_IDLE;
                    load_nxt = 1'b1;
                end else if (sp_p) begin
                    st_nxt = ST_RUN;
                end
            end
            default: begin
                if (clr_p || sp_p) begin
                    st_nxt   = ST_IDLE;
                    load_nxt = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= ST_IDLE;
            load   <= 1'b0;
            cnt_en <= 1'b0;
        end else begin
            st     <= st_nxt;
            load   <= load_nxt;
            cnt_en <= cnt_en_nxt;
        end
    end

    // Heartbeat follows cnt_en; blink phase starts lit and flips every BLINK_TICKS ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb    <= 1'b0;
            phase <= 1'b0;
            bcnt  <= '0;
        end else begin
            if (st_nxt == ST_IDLE) begin
                hb <= 1'b0;
            end else if (cnt_en_nxt) begin
                hb <= ~hb;
            end

            if ((st != ST_DONE) && (st_nxt == ST_DONE)) begin
                phase <= 1'b1;
                bcnt  <= '0;
            end else if ((st == ST_DONE) && tick) begin
                if (bcnt == BLINK_MAX) begin
                    bcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        led = '0;
        case (st)
            ST_RUN:   led = {{(LED_W-1){1'b0}}, hb};
            ST_PAUSE: led = LED_W'(1);
            ST_DONE:  led = {LED_W{phase}};
            default:  led = '0;
        endcase
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with DIV=10, DB_CYCLES=4, BLINK_TICKS=2.
module tb_countdown_ctrl;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_sp;
    logic        btn_clr;
    logic        cnt_zero;
    logic        load;
    logic        cnt_en;
    logic [1:0]  state;
    logic [14:0] led;

    int vectors     = 0;
    int miscompares = 0;

    countdown_ctrl #(
        .CLK_HZ      (100),
        .TICK_HZ     (10),
        .DB_CYCLES   (4),
        .BLINK_TICKS (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_sp   (btn_sp),
        .btn_clr  (btn_clr),
        .cnt_zero (cnt_zero),
        .load     (load),
        .cnt_en   (cnt_en),
        .state    (state),
        .led      (led)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        int pulses;
        int bad_state;
        rst = 1'b1; btn_sp = 1'b0; btn_clr = 1'b0; cnt_zero = 1'b0;
        cyc(3);
        vectors++; if (state !== S_IDLE) begin miscompares++; $display("FAIL reset_state got %0d want 0", state); end
        vectors++; if (led !== 15'h0000) begin miscompares++; $display("FAIL reset_led got %h want 0000", led); end
        vectors++; if (load !== 1'b0) begin miscompares++; $display("FAIL reset_load got %b want 0", load); end
        vectors++; if (cnt_en !== 1'b0) begin miscompares++; $display("FAIL reset_cnt_en got %b want 0", cnt_en); end
        rst = 1'b0;
        pulses = 0; bad_state = 0;
        repeat (20) begin
            @(negedge clk);
            if (load || cnt_en) pulses++;
            if (state !== S_IDLE) bad_state++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL post_reset_pulses got %0d want 0", pulses); end
        vectors++; if (bad_state !== 0) begin miscompares++; $display("FAIL post_reset_state non-idle cycles %0d want 0", bad_state); end
    endtask

    task automatic test_debounce;
        int first_run;
        btn_sp = 1'b1;
        cyc(3);
        btn_sp = 1'b0;
        cyc(15);
        vectors++; if (state !== S_IDLE) begin miscompares++; $display("FAIL glitch_ignored state %0d want 0", state); end
        first_run = -1;
        btn_sp = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (first_run < 0 && state === S_RUN) first_run = i;
            if (i == 10) btn_sp = 1'b0;
        end
        vectors++; if (first_run !== 7) begin miscompares++; $display("FAIL press_to_run cycles %0d want 7", first_run); end
    endtask

    task automatic test_run;
        int n;
        int first;
        int last;
        logic exp_hb;
        n = 0; first = -1; last = -1; exp_hb = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (cnt_en === 1'b1) begin
                n++;
                exp_hb = ~exp_hb;
                if (first < 0) first = i;
                if (last >= 0) begin
                    vectors++; if (i - last !== 10) begin miscompares++; $display("FAIL run_gap got %0d want 10", i - last); end
                end
                last = i;
                vectors++; if (led !== {14'b0, exp_hb}) begin miscompares++; $display("FAIL run_led got %h want %h", led, {14'b0, exp_hb}); end
            end
        end
        vectors++; if (n !== 5) begin miscompares++; $display("FAIL run_pulse_count got %0d want 5", n); end
        vectors++; if (first !== 5) begin miscompares++; $display("FAIL run_first_cnt_en offset %0d want 5", first); end
    endtask

    task automatic test_pause;
        int w;
        int first_pause;
        int bad;
        int en_in_pause;
        int first_run;
        int first_en;
        w = 0;
        while (cnt_en !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        vectors++; if (cnt_en !== 1'b1) begin miscompares++; $display("FAIL pause_sync_tick got %b want 1", cnt_en); end
        cyc(6);
        btn_sp = 1'b1;
        first_pause = -1; bad = 0; en_in_pause = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (first_pause < 0 && state === S_PAUSE) begin
                first_pause = i;
                vectors++; if (led !== 15'h0001) begin miscompares++; $display("FAIL pause_led got %h want 0001", led); end
            end
            if (i >= 8) begin
                if (state !== S_PAUSE) bad++;
                if (cnt_en === 1'b1) en_in_pause++;
            end
            if (i == 10) btn_sp = 1'b0;
        end
        vectors++; if (first_pause !== 7) begin miscompares++; $display("FAIL pause_entry cycles %0d want 7", first_pause); end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL pause_hold non-pause cycles %0d want 0", bad); end
        vectors++; if (en_in_pause !== 0) begin miscompares++; $display("FAIL pause_cnt_en got %0d want 0", en_in_pause); end
        btn_sp = 1'b1;
        first_run = -1; first_en = -1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (first_run < 0 && state === S_RUN) first_run = j;
            if (first_en < 0 && cnt_en === 1'b1) first_en = j;
            if (j == 10) btn_sp = 1'b0;
        end
        vectors++; if (first_run !== 7) begin miscompares++; $display("FAIL resume_entry cycles %0d want 7", first_run); end
        vectors++; if (first_en !== 14) begin miscompares++; $display("FAIL resume_cnt_en cycles %0d want 14", first_en); end
    endtask

    task automatic test_expiry;
        int i;
        int en;
        logic [14:0] exp_led;
        cnt_zero = 1'b1;
        i = 0; en = 0;
        while (state !== S_DONE && i < 15) begin
            @(negedge clk);
            i++;
            if (cnt_en === 1'b1) en++;
        end
        vectors++; if (state !== S_DONE) begin miscompares++; $display("FAIL expiry_state got %0d want 3", state); end
        vectors++; if (i !== 4) begin miscompares++; $display("FAIL expiry_latency got %0d want 4", i); end
        vectors++; if (en !== 0) begin miscompares++; $display("FAIL expiry_cnt_en got %0d want 0", en); end
        for (int c = 0; c < 60; c++) begin
            exp_led = (((c / 20) % 2) == 0) ? 15'h7FFF : 15'h0000;
            vectors++; if (led !== exp_led || cnt_en !== 1'b0) begin miscompares++; $display("FAIL done_blink cycle %0d led %h cnt_en %b want %h 0", c, led, cnt_en, exp_led); end
            @(negedge clk);
        end
    endtask

    task automatic test_priority;
        int loads;
        int first_idle;
        int bad;
        // clear while DONE
        btn_clr = 1'b1; loads = 0; first_idle = -1;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (load === 1'b1) loads++;
            if (first_idle < 0 && state === S_IDLE) begin
                first_idle = i;
                vectors++; if (load !== 1'b1) begin miscompares++; $display("FAIL done_clr_load got %b want 1", load); end
            end
            if (i == 10) btn_clr = 1'b0;
        end
        vectors++; if (first_idle !== 7) begin miscompares++; $display("FAIL done_clr_idle cycles %0d want 7", first_idle); end
        vectors++; if (loads !== 1) begin miscompares++; $display("FAIL done_clr_loads got %0d want 1", loads); end
        // start with nothing to count
        btn_sp = 1'b1; loads = 0; bad = 0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (load === 1'b1) loads++;
            if (state !== S_IDLE) bad++;
            if (i == 10) btn_sp = 1'b0;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL idle_zero_sp non-idle cycles %0d want 0", bad); end
        vectors++; if (loads !== 0) begin miscompares++; $display("FAIL idle_zero_sp loads %0d want 0", loads); end
        // clear while IDLE reloads without leaving IDLE
        btn_clr = 1'b1; loads = 0; bad = 0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (load === 1'b1) loads++;
            if (state !== S_IDLE) bad++;
            if (i == 10) btn_clr = 1'b0;
        end
        vectors++; if (loads !== 1 || bad !== 0) begin miscompares++; $display("FAIL idle_clr loads %0d nonidle %0d want 1 0", loads, bad); end
        // clear and start together in RUN
        cnt_zero = 1'b0;
        btn_sp = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (i == 10) btn_sp = 1'b0;
        end
        vectors++; if (state !== S_RUN) begin miscompares++; $display("FAIL prio_setup_run got %0d want 1", state); end
        btn_sp = 1'b1; btn_clr = 1'b1; loads = 0; bad = 0; first_idle = -1;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (load === 1'b1) loads++;
            if (state === S_PAUSE) bad++;
            if (first_idle < 0 && state === S_IDLE) first_idle = i;
            if (i == 10) begin btn_sp = 1'b0; btn_clr = 1'b0; end
        end
        vectors++; if (first_idle !== 7) begin miscompares++; $display("FAIL prio_idle cycles %0d want 7", first_idle); end
        vectors++; if (loads !== 1) begin miscompares++; $display("FAIL prio_loads got %0d want 1", loads); end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL prio_no_pause pause cycles %0d want 0", bad); end
    endtask

    task automatic test_reset_mid_run;
        int w;
        int pulses;
        int bad_state;
        btn_sp = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (i == 10) btn_sp = 1'b0;
        end
        w = 0;
        while (cnt_en !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        vectors++; if (cnt_en !== 1'b1 || state !== S_RUN) begin miscompares++; $display("FAIL midrun_setup cnt_en %b state %0d want 1 1", cnt_en, state); end
        rst = 1'b1;
        #1;
        vectors++; if (state !== S_IDLE) begin miscompares++; $display("FAIL async_reset_state got %0d want 0", state); end
        vectors++; if (cnt_en !== 1'b0) begin miscompares++; $display("FAIL async_reset_cnt_en got %b want 0", cnt_en); end
        vectors++; if (led !== 15'h0000 || load !== 1'b0) begin miscompares++; $display("FAIL async_reset_led_load led %h load %b want 0000 0", led, load); end
        cyc(2);
        rst = 1'b0;
        pulses = 0; bad_state = 0;
        repeat (20) begin
            @(negedge clk);
            if (load || cnt_en) pulses++;
            if (state !== S_IDLE) bad_state++;
        end
        vectors++; if (pulses !== 0 || bad_state !== 0) begin miscompares++; $display("FAIL midrun_post_reset pulses %0d nonidle %0d want 0 0", pulses, bad_state); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_debounce();
        test_run();
        test_pause();
        test_expiry();
        test_priority();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
